// File: rtl/fpnew_i2fcast_iter.sv
// Iterative integer-to-float cast: normalizes ShiftStep bits per cycle, then rounds once.
// Carries a minimal fpnew_pkg subset so the unit elaborates on its own.

package fpnew_pkg;
    typedef enum logic [2:0] {
        FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
    } fp_format_e;
    typedef enum logic [1:0] {INT8 = 2'd0, INT16 = 2'd1, INT32 = 2'd2, INT64 = 2'd3} int_format_e;
    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;
    localparam int unsigned NUM_INT_FORMATS = 4;
    typedef logic [NUM_INT_FORMATS-1:0] ifmt_logic_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:          return 11;
            FP16, FP8:     return 5;
            default:       return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    function automatic int unsigned int_width(int_format_e ifmt);
        return 8 << ifmt;
    endfunction

    // Formats are ordered by width, so the last enabled one is the widest.
    function automatic int_format_e widest_int_fmt(ifmt_logic_t cfg);
        int_format_e res = INT8;
        for (int unsigned i = 0; i < NUM_INT_FORMATS; i++) begin
            if (cfg[i]) res = int_format_e'(i);
        end
        return res;
    endfunction

    function automatic int unsigned max_int_width(ifmt_logic_t cfg);
        return int_width(widest_int_fmt(cfg));
    endfunction
endpackage

module fpnew_i2fcast_iter #(
    parameter fpnew_pkg::fp_format_e  DstFpFormat  = fpnew_pkg::FP32,
    parameter fpnew_pkg::ifmt_logic_t IntFmtConfig = '1,
    parameter int unsigned            ShiftStep    = 4,
    parameter type                    TagType      = logic,
    localparam int unsigned SRC_WIDTH = fpnew_pkg::max_int_width(IntFmtConfig),
    localparam int unsigned DST_WIDTH = fpnew_pkg::fp_width(DstFpFormat)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [SRC_WIDTH-1:0] operand_i,
    input  logic [2:0]           rnd_mode_i,
    input  logic                 op_mod_i,
    input  logic [1:0]           int_fmt_i,
    input  TagType               tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [DST_WIDTH-1:0] result_o,
    output logic [4:0]           status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);
    localparam int unsigned DST_EXP_BITS = fpnew_pkg::exp_bits(DstFpFormat);
    localparam int unsigned DST_MAN_BITS = fpnew_pkg::man_bits(DstFpFormat);
    localparam int unsigned DST_BIAS     = (1 << (DST_EXP_BITS - 1)) - 1;
    localparam int unsigned EW           = $clog2(SRC_WIDTH) + 1;
    localparam int unsigned EXPW         = ((EW > DST_EXP_BITS) ? EW : DST_EXP_BITS) + 2;
    localparam int unsigned EXTW         = SRC_WIDTH - 1 + DST_MAN_BITS + 2;
    localparam fpnew_pkg::int_format_e WIDEST_FMT = fpnew_pkg::widest_int_fmt(IntFmtConfig);
    localparam logic [EXPW-1:0] EXP_INF  = EXPW'((1 << DST_EXP_BITS) - 1);

    if (ShiftStep < 1 || ShiftStep > SRC_WIDTH || (ShiftStep & (ShiftStep - 1)) != 0) begin : gen_bad_step
        $error("ShiftStep must be a power of two between 1 and SRC_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e               state_q;
    logic [SRC_WIDTH-1:0] mag_q;
    logic [EW-1:0]        e_q;
    logic                 sign_q;
    logic [2:0]           rnd_q;
    TagType               tag_q;
    logic [DST_WIDTH-1:0] result_q;
    logic [4:0]           status_q;

    // Operand preparation
    fpnew_pkg::int_format_e fmt_sel;
    int unsigned            fmt_w;
    logic [SRC_WIDTH-1:0]   low_mask, ext_val, in_mag;
    logic                   msb_in, in_sign;

    always_comb begin
        fmt_sel = IntFmtConfig[int_fmt_i] ? fpnew_pkg::int_format_e'(int_fmt_i) : WIDEST_FMT;
        fmt_w   = fpnew_pkg::int_width(fmt_sel);
        low_mask = '0;
        for (int unsigned i = 0; i < SRC_WIDTH; i++) begin
            low_mask[i] = (i < fmt_w);
        end
        // Top bit of the mask selects the format's sign bit.
        msb_in  = |(operand_i & (low_mask ^ (low_mask >> 1)));
        ext_val = (operand_i & low_mask) | (~low_mask & {SRC_WIDTH{msb_in & ~op_mod_i}});
        in_sign = ext_val[SRC_WIDTH-1] & ~op_mod_i;
        in_mag  = in_sign ? -ext_val : ext_val;
    end

    // One normalization step
    logic [ShiftStep-1:0] top_bits;
    logic                 top_zero, found;
    logic [EW-1:0]        lz_top, e_norm;
    logic [SRC_WIDTH-1:0] mag_norm;

    always_comb begin
        top_bits = mag_q[SRC_WIDTH-1 -: ShiftStep];
        top_zero = ~|top_bits;
        lz_top   = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < ShiftStep; i++) begin
            if (!found && top_bits[ShiftStep-1-i]) begin
                lz_top = EW'(i);
                found  = 1'b1;
            end
        end
        mag_norm = top_zero ? (mag_q << ShiftStep) : (mag_q << lz_top);
        e_norm   = e_q - (top_zero ? EW'(ShiftStep) : lz_top);
    end

    // Rounding and overflow saturation
    logic [EXTW-1:0]         ext_man;
    logic [DST_MAN_BITS-1:0] man_pre;
    logic [DST_MAN_BITS:0]   man_rnd;
    logic                    rnd_bit, sticky, round_up, ovf, use_inf;
    logic [EXPW-1:0]         exp_pre, exp_post;
    logic [DST_WIDTH-1:0]    res_norm, res_sat;

    always_comb begin
        // The leading one is implicit; bits past the operand are zero-padded.
        ext_man = {mag_q[SRC_WIDTH-2:0], {(DST_MAN_BITS + 2){1'b0}}};
        man_pre = ext_man[EXTW-1 -: DST_MAN_BITS];
        rnd_bit = ext_man[EXTW-1-DST_MAN_BITS];
        sticky  = |ext_man[EXTW-2-DST_MAN_BITS:0];
        case (rnd_q)
            fpnew_pkg::RTZ: begin round_up = 1'b0;                         use_inf = 1'b0;    end
            fpnew_pkg::RDN: begin round_up = sign_q & (rnd_bit | sticky);  use_inf = sign_q;  end
            fpnew_pkg::RUP: begin round_up = ~sign_q & (rnd_bit | sticky); use_inf = ~sign_q; end
            fpnew_pkg::RMM: begin round_up = rnd_bit;                      use_inf = 1'b1;    end
            default:        begin round_up = rnd_bit & (sticky | man_pre[0]); use_inf = 1'b1; end
        endcase
        man_rnd  = {1'b0, man_pre} + {{DST_MAN_BITS{1'b0}}, round_up};
        exp_pre  = EXPW'(e_q) + EXPW'(DST_BIAS);
        exp_post = exp_pre + {{(EXPW - 1){1'b0}}, man_rnd[DST_MAN_BITS]};
        ovf      = (exp_post >= EXP_INF);
        res_norm = {sign_q, exp_post[DST_EXP_BITS-1:0], man_rnd[DST_MAN_BITS-1:0]};
        res_sat  = use_inf ? {sign_q, {DST_EXP_BITS{1'b1}}, {DST_MAN_BITS{1'b0}}}
                           : {sign_q, {(DST_EXP_BITS - 1){1'b1}}, 1'b0, {DST_MAN_BITS{1'b1}}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mag_q    <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            rnd_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        mag_q  <= in_mag;
                        sign_q <= in_sign;
                        e_q    <= EW'(SRC_WIDTH - 1);
                        rnd_q  <= rnd_mode_i;
                        tag_q  <= tag_i;
                        if (in_mag == '0) begin
                            result_q <= '0;
                            status_q <= '0;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StNorm;
                        end
                    end
                end
                StNorm: begin
                    mag_q <= mag_norm;
                    e_q   <= e_norm;
                    if (!top_zero) state_q <= StRound;
                end
                StRound: begin
                    result_q <= ovf ? res_sat : res_norm;
                    status_q <= {2'b00, ovf, 1'b0, ovf | rnd_bit | sticky};
                    state_q  <= StDone;
                end
                StDone: begin
                    if (out_ready_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o      = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign out_valid_o     = (state_q == StDone);
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign tag_o           = tag_q;
    assign extension_bit_o = 1'b1;
endmodule

// File: tb/tb_fpnew_i2fcast_iter.sv
// Scoreboard bench for the iterative int-to-float cast, FP32 and FP16 instances side by side.

module tb_fpnew_i2fcast_iter;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  status;
        logic [3:0]  tag;
        int          lat;
    } exp_t;

    logic        clk, rst;
    logic [63:0] operand;
    logic [2:0]  rnd;
    logic        op_mod;
    logic [1:0]  int_fmt;
    logic [3:0]  tag_in;
    logic        flush, out_ready, vld32, vld16;
    logic        ir32, ir16, ov32, ov16, busy32, busy16, ext32, ext16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic [4:0]  st32, st16;
    logic [3:0]  tag32, tag16;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    logic [3:0]  tag_cnt = 4'd1;

    fpnew_i2fcast_iter #(
        .DstFpFormat (fpnew_pkg::FP32),
        .IntFmtConfig('1),
        .ShiftStep   (4),
        .TagType     (logic [3:0])
    ) u_dut32 (
        .clk_i(clk), .rst_i(rst), .operand_i(operand), .rnd_mode_i(rnd), .op_mod_i(op_mod),
        .int_fmt_i(int_fmt), .tag_i(tag_in), .in_valid_i(vld32), .in_ready_o(ir32),
        .flush_i(flush), .result_o(res32), .status_o(st32), .extension_bit_o(ext32),
        .tag_o(tag32), .out_valid_o(ov32), .out_ready_i(out_ready), .busy_o(busy32)
    );

    fpnew_i2fcast_iter #(
        .DstFpFormat (fpnew_pkg::FP16),
        .IntFmtConfig('1),
        .ShiftStep   (4),
        .TagType     (logic [3:0])
    ) u_dut16 (
        .clk_i(clk), .rst_i(rst), .operand_i(operand), .rnd_mode_i(rnd), .op_mod_i(op_mod),
        .int_fmt_i(int_fmt), .tag_i(tag_in), .in_valid_i(vld16), .in_ready_o(ir16),
        .flush_i(flush), .result_o(res16), .status_o(st16), .extension_bit_o(ext16),
        .tag_o(tag16), .out_valid_o(ov16), .out_ready_i(out_ready), .busy_o(busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference conversion: locate the MSB and round by comparing the remainder to half an ulp.
    function automatic void ref_cvt(input logic [63:0] op, input logic [1:0] fmt, input logic opm,
                                    input logic [2:0] rm, input int eb, input int mb,
                                    output logic [31:0] res, output logic [4:0] st,
                                    output int lat);
        int          w, p, e;
        logic [63:0] v, mag, man, rem, half, r64;
        logic        sgn, up, inf;
        w = 8 << fmt;
        for (int i = 0; i < 64; i++) v[i] = (i < w) ? op[i] : (~opm & op[w-1]);
        sgn = v[63] & ~opm;
        mag = sgn ? -v : v;
        if (mag == 64'd0) begin
            res = '0;
            st  = '0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        lat = (63 - p) / 4 + 3;
        e = p + (1 << (eb - 1)) - 1;
        if (p > mb) begin
            man  = (mag >> (p - mb)) & ((64'd1 << mb) - 64'd1);
            rem  = mag & ((64'd1 << (p - mb)) - 64'd1);
            half = 64'd1 << (p - mb - 1);
        end else begin
            man  = (mag << (mb - p)) & ((64'd1 << mb) - 64'd1);
            rem  = 64'd0;
            half = 64'd1;
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && (rem != 0);
            3'd3:    up = !sgn && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || (rem == half && man[0]);
        endcase
        if (up) begin
            man = man + 64'd1;
            if (man == (64'd1 << mb)) begin
                man = 64'd0;
                e++;
            end
        end
        if (e >= (1 << eb) - 1) begin
            inf = (rm == 3'd2) ? sgn : (rm == 3'd3) ? !sgn : (rm != 3'd1);
            st  = 5'b00101;
            if (inf) r64 = (64'(sgn) << (eb + mb)) | (64'((1 << eb) - 1) << mb);
            else r64 = (64'(sgn) << (eb + mb)) | (64'((1 << eb) - 2) << mb)
                       | ((64'd1 << mb) - 64'd1);
        end else begin
            st  = {4'b0000, rem != 0};
            r64 = (64'(sgn) << (eb + mb)) | (64'(e) << mb) | man;
        end
        res = r64[31:0];
    endfunction

    // Drives one operation, holds out_ready low for 'hold' cycles once the result is valid.
    task automatic run_op(input bit h, input logic [63:0] op, input logic [1:0] fmt,
                          input logic opm, input logic [2:0] rm, input logic [31:0] xres,
                          input logic [4:0] xst, input int xlat, input int hold);
        exp_t        x;
        int          n;
        logic        g_ov, g_ir;
        logic [31:0] g_res;
        logic [4:0]  g_st;
        logic [3:0]  g_tag;
        operand   = op;
        int_fmt   = fmt;
        op_mod    = opm;
        rnd       = rm;
        tag_in    = tag_cnt;
        out_ready = (hold == 0);
        check("in_ready_idle", {63'd0, h ? ir16 : ir32}, 64'd1);
        if (h) vld16 = 1'b1;
        else vld32 = 1'b1;
        @(posedge clk); #1;
        vld16 = 1'b0;
        vld32 = 1'b0;
        sb_q.push_back('{xres, xst, tag_cnt, xlat});
        tag_cnt++;
        n = 0;
        while (!(h ? ov16 : ov32) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        x     = sb_q.pop_front();
        g_ov  = h ? ov16 : ov32;
        g_ir  = h ? ir16 : ir32;
        g_res = h ? {16'h0, res16} : res32;
        g_st  = h ? st16 : st32;
        g_tag = h ? tag16 : tag32;
        check("out_valid", {63'd0, g_ov}, 64'd1);
        check("latency", 64'(n + 1), 64'(x.lat));
        check("result", {32'd0, g_res}, {32'd0, x.res});
        check("status", {59'd0, g_st}, {59'd0, x.status});
        check("tag", {60'd0, g_tag}, {60'd0, x.tag});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            g_ov  = h ? ov16 : ov32;
            g_ir  = h ? ir16 : ir32;
            g_res = h ? {16'h0, res16} : res32;
            g_st  = h ? st16 : st32;
            check("hold_stable", {25'd0, g_ov, g_ir, g_res, g_st},
                  {25'd0, 1'b1, 1'b0, x.res, x.status});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rand_op(input bit h);
        logic [63:0] op;
        logic [1:0]  fmt;
        logic        opm;
        logic [2:0]  rm;
        logic [31:0] r;
        logic [4:0]  s;
        int          l;
        op  = {$urandom, $urandom} >> $urandom_range(0, 63);
        fmt = 2'($urandom_range(0, 3));
        opm = 1'($urandom_range(0, 1));
        rm  = 3'($urandom_range(0, 4));
        ref_cvt(op, fmt, opm, rm, h ? 5 : 8, h ? 10 : 23, r, s, l);
        run_op(h, op, fmt, opm, rm, r, s, l, 0);
    endtask

    initial begin
        logic any_valid;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; vld32 = 1'b0; vld16 = 1'b0;
        operand = '0; rnd = '0; op_mod = 1'b0; int_fmt = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl32", {60'd0, ov32, busy32, ir32, ext32}, 64'b0011);
        check("reset_ctl16", {60'd0, ov16, busy16, ir16, ext16}, 64'b0011);
        check("reset_out32", {23'd0, res32, st32, tag32}, 64'd0);
        rst = 1'b0;

        // FP32 directed vectors
        run_op(0, 64'hFFFF_FFFF, 2'd2, 1'b0, 3'd0, 32'hBF80_0000, 5'b00000, 18, 0);
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 3'd0, 32'h5F80_0000, 5'b00001, 3, 0);
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 3'd1, 32'h5F7F_FFFF, 5'b00001, 3, 0);
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 3'd7, 32'h5F80_0000, 5'b00001, 3, 0);
        run_op(0, 64'h0100_0001, 2'd2, 1'b0, 3'd0, 32'h4B80_0000, 5'b00001, 12, 0);
        run_op(0, 64'h0100_0001, 2'd2, 1'b0, 3'd3, 32'h4B80_0001, 5'b00001, 12, 0);
        run_op(0, 64'h0, 2'd2, 1'b0, 3'd0, 32'h0000_0000, 5'b00000, 1, 0);
        // Backpressure: -128 from INT8 held for five cycles
        run_op(0, 64'hFFFF_0080, 2'd0, 1'b0, 3'd0, 32'hC300_0000, 5'b00000, 17, 5);

        // FP16 overflow vectors
        run_op(1, 64'h0001_1170, 2'd2, 1'b0, 3'd0, 32'h0000_7C00, 5'b00101, 14, 0);
        run_op(1, 64'h0001_1170, 2'd2, 1'b0, 3'd1, 32'h0000_7BFF, 5'b00101, 14, 0);
        run_op(1, 64'hFFFE_EE90, 2'd2, 1'b0, 3'd3, 32'h0000_FBFF, 5'b00101, 14, 0);

        for (int i = 0; i < 24; i++) rand_op(0);
        for (int i = 0; i < 12; i++) rand_op(1);

        // Flush mid-normalization
        operand = 64'hFFFF_FFFF; int_fmt = 2'd2; op_mod = 1'b0; rnd = 3'd0;
        vld32 = 1'b1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_flush", {63'd0, busy32}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ctl", {61'd0, ov32, ir32, busy32}, 64'b010);
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            any_valid = any_valid | ov32;
        end
        check("no_valid_after_flush", {63'd0, any_valid}, 64'd0);
        run_op(0, 64'h0100_0001, 2'd2, 1'b0, 3'd3, 32'h4B80_0001, 5'b00001, 12, 0);

        // Reset mid-normalization
        operand = 64'hFFFF_FFFF; int_fmt = 2'd2; op_mod = 1'b0; tag_in = 4'hA;
        vld32 = 1'b1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_reset", {63'd0, busy32}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_ctl", {60'd0, ov32, busy32, ir32, ext32}, 64'b0011);
        check("midreset_out", {23'd0, res32, st32, tag32}, 64'd0);
        run_op(0, 64'hFFFF_FFFF, 2'd2, 1'b0, 3'd0, 32'hBF80_0000, 5'b00000, 18, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
